// File: rtl/mist1032isa_fetch_pkg.sv
// Shared definitions for the fetch-side unpacker: state encoding and entry layout.
package mist1032isa_fetch_pkg;

   localparam int WORD_N      = 32;
   localparam int LANE_LO_BIT = 2*WORD_N;
   localparam int LANE_HI_BIT = 2*WORD_N + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/mist1032isa_fetch_unpacker.sv
// Splits lane-masked 64-bit fetch entries into a stream of 32-bit words,
// popping the next entry on the same edge as the last word of the current one.
module mist1032isa_fetch_unpacker #(
   parameter int WORD_N  = 32,
   parameter int ENTRY_N = 2*WORD_N + 2
) (
   input  logic               iCLOCK,
   input  logic               iRESET,
   input  logic               iREMOVE,
   input  logic               iFIFO_EMPTY,
   input  logic [ENTRY_N-1:0] iFIFO_DATA,
   output logic               oFIFO_RD,
   output logic               oVALID,
   output logic [WORD_N-1:0]  oDATA,
   output logic               oLANE,
   input  logic               iBUSY
);
   import mist1032isa_fetch_pkg::*;

   fetch_state_t       b_state;
   logic [ENTRY_N-1:0] b_entry;
   fetch_state_t       load_state;
   logic               xfer;
   logic               last;
   logic               pop;

   assign xfer = (b_state != IDLE) && !iBUSY;
   assign last = xfer && ((b_state == HI) || ((b_state == LO) && !b_entry[LANE_HI_BIT]));
   // The FIFO does not guard reads on empty, so the empty check must stay here.
   assign pop  = !iRESET && !iREMOVE && !iFIFO_EMPTY && ((b_state == IDLE) || last);

   always_comb begin
      load_state = IDLE;
      case ({iFIFO_DATA[LANE_HI_BIT], iFIFO_DATA[LANE_LO_BIT]})
         2'b01, 2'b11: load_state = LO;
         2'b10:        load_state = HI;
         default:      load_state = IDLE;
      endcase
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         b_state <= IDLE;
         b_entry <= '0;
      end else if (iREMOVE) begin
         b_state <= IDLE;
      end else if (pop) begin
         b_entry <= iFIFO_DATA;
         b_state <= load_state;
      end else if (last) begin
         b_state <= IDLE;
      end else if (xfer) begin
         // Only a LO word with the upper lane still pending gets here.
         b_state <= HI;
      end
   end

   assign oFIFO_RD = pop;
   assign oVALID   = (b_state != IDLE);
   assign oLANE    = (b_state == HI);
   assign oDATA    = (b_state == HI) ? b_entry[2*WORD_N-1:WORD_N] : b_entry[WORD_N-1:0];

endmodule

// File: tb/tb_mist1032isa_fetch_unpacker.sv
// Bench: queue-modelled FIFO feeding the unpacker; output words checked against lane-mask expansion.
module tb_mist1032isa_fetch_unpacker;
   localparam int W = 32;

   logic           iCLOCK = 1'b0;
   logic           iRESET;
   logic           iREMOVE;
   logic           iFIFO_EMPTY;
   logic [2*W+1:0] iFIFO_DATA;
   logic           oFIFO_RD;
   logic           oVALID;
   logic [W-1:0]   oDATA;
   logic           oLANE;
   logic           iBUSY;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_pops  = 0;
   int n_viol  = 0;

   logic [2*W+1:0] fifo_q[$];
   logic [W:0]     exp_q[$];
   logic [W:0]     out_q[$];
   int             out_cyc[$];

   mist1032isa_fetch_unpacker #(.WORD_N(W), .ENTRY_N(2*W+2)) dut (
      .iCLOCK(iCLOCK), .iRESET(iRESET), .iREMOVE(iREMOVE),
      .iFIFO_EMPTY(iFIFO_EMPTY), .iFIFO_DATA(iFIFO_DATA), .oFIFO_RD(oFIFO_RD),
      .oVALID(oVALID), .oDATA(oDATA), .oLANE(oLANE), .iBUSY(iBUSY)
   );

   always #5 iCLOCK = ~iCLOCK;

   task automatic drive_fifo();
      iFIFO_EMPTY = (fifo_q.size() == 0);
      iFIFO_DATA  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
   endtask

   // Reference model: an entry yields its lower word then its upper word, each only if its mask bit is set.
   task automatic push_entry(input logic [1:0] mask, input logic [W-1:0] hi, input logic [W-1:0] lo);
      fifo_q.push_back({mask, hi, lo});
      if (mask[0]) exp_q.push_back({1'b0, lo});
      if (mask[1]) exp_q.push_back({1'b1, hi});
      drive_fifo();
   endtask

   task automatic clear_logs();
      exp_q.delete();
      out_q.delete();
      out_cyc.delete();
      n_pops = 0;
   endtask

   // One clock: sample at the falling edge, apply the FIFO pop just after the rising edge.
   task automatic cycle();
      logic s_rd;
      logic s_xfer;
      @(negedge iCLOCK);
      s_rd   = oFIFO_RD;
      s_xfer = oVALID && !iBUSY && !iREMOVE;
      if (s_rd && iFIFO_EMPTY) begin
         n_viol++;
         $display("FAIL empty_guard: oFIFO_RD=1 while iFIFO_EMPTY=1 at cycle %0d", cyc);
      end
      if (s_xfer) begin
         out_q.push_back({oLANE, oDATA});
         out_cyc.push_back(cyc);
      end
      @(posedge iCLOCK);
      #1;
      cyc++;
      if (s_rd && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
         n_pops++;
      end
      drive_fifo();
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      iBUSY = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (fifo_q.size() == 0 && !oVALID) begin
            ok = 1'b1;
            return;
         end
         cycle();
      end
   endtask

   task automatic test_reset();
      bit ok;
      iRESET = 1'b1; iREMOVE = 1'b0; iBUSY = 1'b0;
      clear_logs();
      push_entry(2'b11, 32'hA5A5_0001, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_tests++;
         if (oFIFO_RD !== 1'b0 || oVALID !== 1'b0 || oDATA !== '0 || oLANE !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_outputs: rd=%b valid=%b data=%h lane=%b required 0 0 0 0", oFIFO_RD, oVALID, oDATA, oLANE);
         end
      end
      iRESET = 1'b0;
      #1;
      n_tests++;
      if (oFIFO_RD !== 1'b1) begin
         n_fail++; $display("FAIL rst_release_pop: oFIFO_RD=%b required 1", oFIFO_RD);
      end
      cycle();
      n_tests++;
      if (oVALID !== 1'b1 || oDATA !== 32'h1234_5678 || oLANE !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_first_word: valid=%b data=%h lane=%b required 1 12345678 0", oVALID, oDATA, oLANE);
      end
      drain(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rst_drain: timeout got 0 required 1"); end
      n_tests++;
      if (out_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rst_count: got %0d words required %0d", out_q.size(), exp_q.size());
      end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (out_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL rst_word[%0d]: got %h required %h", i, out_q[i], exp_q[i]);
         end
      end
      $display("[TB] test_reset done, %0d words", out_q.size());
   endtask

   task automatic test_stream();
      bit ok;
      int c0;
      clear_logs();
      iBUSY = 1'b0;
      push_entry(2'b11, 32'hA1A1_A1A1, 32'hA0A0_A0A0);
      push_entry(2'b11, 32'hB1B1_B1B1, 32'hB0B0_B0B0);
      push_entry(2'b11, 32'hC1C1_C1C1, 32'hC0C0_C0C0);
      c0 = cyc;
      for (int i = 0; i < 10; i++) cycle();
      drain(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL stream_drain: timeout got 0 required 1"); end
      n_tests++;
      if (out_q.size() != 6) begin
         n_fail++; $display("FAIL stream_count: got %0d words required 6", out_q.size());
      end
      n_tests++;
      if (n_pops != 3) begin
         n_fail++; $display("FAIL stream_pops: got %0d required 3", n_pops);
      end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (out_q[i] !== exp_q[i] || out_cyc[i] != c0 + 1 + i) begin
            n_fail++;
            $display("FAIL stream_word[%0d]: got %h at cycle %0d required %h at cycle %0d",
                     i, out_q[i], out_cyc[i], exp_q[i], c0 + 1 + i);
         end
      end
      n_tests++;
      if (oVALID !== 1'b0 || iFIFO_EMPTY !== 1'b1) begin
         n_fail++; $display("FAIL stream_idle: valid=%b empty=%b required 0 1", oVALID, iFIFO_EMPTY);
      end
      $display("[TB] test_stream done, %0d words, %0d pops", out_q.size(), n_pops);
   endtask

   task automatic test_lanes();
      bit ok;
      clear_logs();
      iBUSY = 1'b0;
      push_entry(2'b10, 32'hD1D1_0001, 32'hDEAD_BEEF);
      push_entry(2'b01, 32'hDEAD_BEEF, 32'hE0E0_0002);
      push_entry(2'b00, 32'h5555_5555, 32'hAAAA_AAAA);
      push_entry(2'b11, 32'hF1F1_0004, 32'hF0F0_0003);
      drain(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL lanes_drain: timeout got 0 required 1"); end
      n_tests++;
      if (out_q.size() != 4 || n_pops != 4) begin
         n_fail++; $display("FAIL lanes_count: got %0d words %0d pops required 4 4", out_q.size(), n_pops);
      end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (out_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL lanes_word[%0d]: got %h required %h", i, out_q[i], exp_q[i]);
         end
      end
      $display("[TB] test_lanes done, %0d words, %0d pops", out_q.size(), n_pops);
   endtask

   task automatic test_stall();
      bit ok;
      logic [W-1:0] held;
      int guard;
      clear_logs();
      iBUSY = 1'b0;
      push_entry(2'b11, 32'h6161_0001, 32'h6060_0000);
      push_entry(2'b11, 32'h7171_0003, 32'h7070_0002);
      guard = 0;
      while (!(oVALID === 1'b1 && oLANE === 1'b1) && guard < 20) begin
         cycle();
         guard++;
      end
      n_tests++;
      if (guard >= 20) begin n_fail++; $display("FAIL stall_reach_hi: timeout got 0 required 1"); end
      held = oDATA;
      iBUSY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_tests++;
         if (oFIFO_RD !== 1'b0 || oDATA !== held || oLANE !== 1'b1 || oVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: rd=%b data=%h lane=%b valid=%b required 0 %h 1 1",
                     i, oFIFO_RD, oDATA, oLANE, oVALID, held);
         end
         cycle();
      end
      drain(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL stall_drain: timeout got 0 required 1"); end
      n_tests++;
      if (out_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL stall_count: got %0d words required %0d", out_q.size(), exp_q.size());
      end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (out_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL stall_word[%0d]: got %h required %h", i, out_q[i], exp_q[i]);
         end
      end
      $display("[TB] test_stall done, %0d words", out_q.size());
   endtask

   task automatic test_flush();
      bit ok;
      clear_logs();
      iBUSY = 1'b0;
      push_entry(2'b11, 32'h8181_0001, 32'h8080_0000);
      push_entry(2'b11, 32'h8383_0003, 32'h8282_0002);
      push_entry(2'b11, 32'h8585_0005, 32'h8484_0004);
      cycle();
      iREMOVE = 1'b1;
      #1;
      n_tests++;
      if (oFIFO_RD !== 1'b0) begin n_fail++; $display("FAIL flush_rd: oFIFO_RD=%b required 0", oFIFO_RD); end
      cycle();
      iREMOVE = 1'b0;
      // Parent flushes the FIFO on the same edge.
      fifo_q.delete();
      drive_fifo();
      clear_logs();
      #1;
      n_tests++;
      if (oVALID !== 1'b0 || oFIFO_RD !== 1'b0) begin
         n_fail++; $display("FAIL flush_idle: valid=%b rd=%b required 0 0", oVALID, oFIFO_RD);
      end
      push_entry(2'b11, 32'h9191_0001, 32'h9090_0000);
      #1;
      n_tests++;
      if (oFIFO_RD !== 1'b1) begin n_fail++; $display("FAIL flush_repop: oFIFO_RD=%b required 1", oFIFO_RD); end
      cycle();
      n_tests++;
      if (oVALID !== 1'b1 || oDATA !== 32'h9090_0000 || oLANE !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_first_word: valid=%b data=%h lane=%b required 1 90900000 0", oVALID, oDATA, oLANE);
      end
      drain(ok);
      n_tests++;
      if (!ok || out_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL flush_count: got %0d words required %0d", out_q.size(), exp_q.size());
      end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (out_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL flush_word[%0d]: got %h required %h", i, out_q[i], exp_q[i]);
         end
      end
      $display("[TB] test_flush done, %0d words", out_q.size());
   endtask

   task automatic test_random();
      bit ok;
      int n_bad;
      clear_logs();
      for (int i = 0; i < 10000; i++) begin
         iBUSY = ($urandom_range(0, 3) == 0);
         if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1)
            push_entry(2'($urandom_range(0, 3)), $urandom, $urandom);
         cycle();
      end
      drain(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL random_drain: timeout got 0 required 1"); end
      n_tests++;
      if (n_viol != 0) begin n_fail++; $display("FAIL random_empty_guard: got %0d violations required 0", n_viol); end
      n_tests++;
      if (out_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL random_count: got %0d words required %0d", out_q.size(), exp_q.size());
      end
      n_bad = 0;
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (out_q[i] !== exp_q[i]) begin
            n_fail++;
            n_bad++;
            if (n_bad <= 10) $display("FAIL random_word[%0d]: got %h required %h", i, out_q[i], exp_q[i]);
         end
      end
      $display("[TB] test_random done, %0d words, %0d pops", out_q.size(), n_pops);
   endtask

   initial begin
      iRESET = 1'b1;
      iREMOVE = 1'b0;
      iBUSY = 1'b0;
      iFIFO_EMPTY = 1'b1;
      iFIFO_DATA = '0;
      test_reset();
      test_stream();
      test_lanes();
      test_stall();
      test_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
